// File: rtl/ssd_scan_if.sv
`default_nettype none
// ============================================================================
// Module      : ssd_scan_if
// Description : Bundle between the digit decoders and the seven-segment scan
//               driver: per-digit segment words, blank mask, load strobe,
//               and the scanned display outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface ssd_scan_if #(
  parameter int SSD_BIT_WIDTH = 8
);
  logic [SSD_BIT_WIDTH-1:0] in0;
  logic [SSD_BIT_WIDTH-1:0] in1;
  logic [SSD_BIT_WIDTH-1:0] in2;
  logic [SSD_BIT_WIDTH-1:0] in3;
  logic [3:0]               blank;
  logic                     load;
  logic                     pending;
  logic [SSD_BIT_WIDTH-1:0] segs;
  logic [3:0]               ssd_ctl;
  logic                     frame;

  // Upstream side: supplies digit values, observes the display.
  modport master (
    output in0, in1, in2, in3, blank, load,
    input  pending, segs, ssd_ctl, frame
  );

  // Scan driver side.
  modport slave (
    input  in0, in1, in2, in3, blank, load,
    output pending, segs, ssd_ctl, frame
  );
endinterface
`default_nettype wire

// File: rtl/ssd_scan.sv
`default_nettype none
// ============================================================================
// Module      : ssd_scan
// Description : Four-digit seven-segment scan driver. Double-buffers digit
//               values (shadow/active banks swapped at frame boundaries),
//               inserts dead time at the start of each digit slot, and drives
//               the shared active-low segment bus and digit enables.
// Revision    : 1.0 - initial release
// ============================================================================
module ssd_scan #(
  parameter int                       PRESCALE      = 100000,
  parameter int                       DEAD          = 1000,
  parameter int                       SSD_BIT_WIDTH = 8,
  parameter logic [SSD_BIT_WIDTH-1:0] SS_DEF        = '1
) (
  input  logic       clk,
  input  logic       rst,
  ssd_scan_if.slave  bus
);

  localparam int            CW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] DEAD_C  = CW'(DEAD);

  logic [CW-1:0]                   cnt_q, cnt_d;
  logic [1:0]                      idx_q, idx_d;
  logic [3:0][SSD_BIT_WIDTH-1:0]   shd_word_q, shd_word_d;
  logic [3:0]                      shd_blank_q, shd_blank_d;
  logic [3:0][SSD_BIT_WIDTH-1:0]   act_word_q, act_word_d;
  logic [3:0]                      act_blank_q, act_blank_d;
  logic                            pending_q, pending_d;
  logic [SSD_BIT_WIDTH-1:0]        segs_q, segs_d;
  logic [3:0]                      ctl_q, ctl_d;
  logic                            frame_q, frame_d;

  logic [3:0][SSD_BIT_WIDTH-1:0]   in_words;
  logic                            wrap;
  logic                            dark;

  // Index 0 is the rightmost digit.
  assign in_words = {bus.in3, bus.in2, bus.in1, bus.in0};

  // Next-state: slot counter, bank capture/swap, and output decode.
  always_comb begin
    cnt_d       = cnt_q + CW'(1);
    idx_d       = idx_q;
    shd_word_d  = shd_word_q;
    shd_blank_d = shd_blank_q;
    act_word_d  = act_word_q;
    act_blank_d = act_blank_q;
    pending_d   = pending_q;

    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end

    wrap = (idx_q == 2'd3) && (cnt_q == CNT_MAX);

    if (bus.load) begin
      // A load always refreshes the shadow bank; on the wrap edge it also
      // bypasses straight into the active bank so nothing is left pending.
      shd_word_d  = in_words;
      shd_blank_d = bus.blank;
      if (wrap) begin
        act_word_d  = in_words;
        act_blank_d = bus.blank;
        pending_d   = 1'b0;
      end else begin
        pending_d   = 1'b1;
      end
    end else if (wrap && pending_q) begin
      act_word_d  = shd_word_q;
      act_blank_d = shd_blank_q;
      pending_d   = 1'b0;
    end

    // Decode uses the current slot position but the bank as it will be after
    // this edge, so a swap on the wrap edge is visible immediately.
    dark   = (cnt_q < DEAD_C) || act_blank_d[idx_q];
    segs_d = dark ? SS_DEF : act_word_d[idx_q];
    ctl_d  = dark ? 4'b1111 : ~(4'b0001 << idx_q);

    frame_d = wrap;
  end

  // State and registered outputs, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      idx_q       <= 2'd0;
      shd_word_q  <= {4{SS_DEF}};
      shd_blank_q <= 4'b0000;
      act_word_q  <= {4{SS_DEF}};
      act_blank_q <= 4'b0000;
      pending_q   <= 1'b0;
      segs_q      <= SS_DEF;
      ctl_q       <= 4'b1111;
      frame_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shd_word_q  <= shd_word_d;
      shd_blank_q <= shd_blank_d;
      act_word_q  <= act_word_d;
      act_blank_q <= act_blank_d;
      pending_q   <= pending_d;
      segs_q      <= segs_d;
      ctl_q       <= ctl_d;
      frame_q     <= frame_d;
    end
  end

  assign bus.pending = pending_q;
  assign bus.segs    = segs_q;
  assign bus.ssd_ctl = ctl_q;
  assign bus.frame   = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_ssd_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_ssd_scan
// Description : Directed self-checking bench for ssd_scan (PRESCALE=8,
//               DEAD=2): reset, scan pattern, double buffering, last-load
//               wins, blanking and reset during operation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ssd_scan;

  localparam int        PRESCALE = 8;
  localparam int        DEAD     = 2;
  localparam int        W        = 8;
  localparam logic [7:0] SS_DEF  = 8'hFF;
  localparam logic [7:0] SS_0    = 8'hC0;
  localparam logic [7:0] SS_1    = 8'hF9;
  localparam logic [7:0] SS_2    = 8'hA4;
  localparam logic [7:0] SS_3    = 8'hB0;
  localparam logic [7:0] SS_5    = 8'h92;
  localparam logic [7:0] SS_7    = 8'hF8;
  localparam logic [7:0] SS_9    = 8'h90;

  // Digit enables over one 32-cycle frame, written out by hand.
  localparam logic [3:0] SCAN_CTL [0:31] = '{
    4'hF, 4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE,
    4'hF, 4'hF, 4'hD, 4'hD, 4'hD, 4'hD, 4'hD, 4'hD,
    4'hF, 4'hF, 4'hB, 4'hB, 4'hB, 4'hB, 4'hB, 4'hB,
    4'hF, 4'hF, 4'h7, 4'h7, 4'h7, 4'h7, 4'h7, 4'h7
  };

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ssd_scan_if #(.SSD_BIT_WIDTH(W)) bus ();

  ssd_scan #(
    .PRESCALE      (PRESCALE),
    .DEAD          (DEAD),
    .SSD_BIT_WIDTH (W),
    .SS_DEF        (SS_DEF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int ph    = 0;   // slot position (idx*8+cnt) the next edge decodes
  int fr    = 0;

  logic [7:0] m_sh  [4];
  logic [7:0] m_act [4];
  logic [3:0] m_shb;
  logic [3:0] m_actb;
  logic       m_pend;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_sh[i]  = SS_DEF;
      m_act[i] = SS_DEF;
    end
    m_shb  = 4'b0000;
    m_actb = 4'b0000;
    m_pend = 1'b0;
    ph     = 0;
  endtask

  // One clock edge: update the expected banks, then check every output.
  task automatic step();
    int         dec;
    int         idx;
    bit         wrp;
    bit         dk;
    logic [7:0] in_w [4];
    logic [3:0] one;
    logic [3:0] e_ctl;
    logic [7:0] e_seg;
    @(posedge clk);
    dec = ph;
    wrp = (dec == 31);
    in_w[0] = bus.in0; in_w[1] = bus.in1; in_w[2] = bus.in2; in_w[3] = bus.in3;
    if (bus.load) begin
      for (int i = 0; i < 4; i++) m_sh[i] = in_w[i];
      m_shb = bus.blank;
      if (wrp) begin
        for (int i = 0; i < 4; i++) m_act[i] = in_w[i];
        m_actb = bus.blank;
        m_pend = 1'b0;
      end else begin
        m_pend = 1'b1;
      end
    end else if (wrp && m_pend) begin
      for (int i = 0; i < 4; i++) m_act[i] = m_sh[i];
      m_actb = m_shb;
      m_pend = 1'b0;
    end
    ph = (ph + 1) % 32;
    #1;
    idx   = dec / 8;
    dk    = ((dec % 8) < DEAD) || m_actb[idx];
    one   = 4'b0001 << idx;
    e_ctl = dk ? 4'hF : ~one;
    e_seg = dk ? SS_DEF : m_act[idx];
    chk($sformatf("ctl@%0d", dec),   32'(bus.ssd_ctl), 32'(e_ctl));
    chk($sformatf("segs@%0d", dec),  32'(bus.segs),    32'(e_seg));
    chk($sformatf("pend@%0d", dec),  32'(bus.pending), 32'(m_pend));
    chk($sformatf("frame@%0d", dec), 32'(bus.frame),   32'(wrp));
  endtask

  task automatic run_to(input int p);
    while (ph != p) step();
  endtask

  task automatic load_vals(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d,
                           input logic [3:0] bl);
    bus.in0   = a;
    bus.in1   = b;
    bus.in2   = c;
    bus.in3   = d;
    bus.blank = bl;
    bus.load  = 1'b1;
    step();
    bus.load  = 1'b0;
  endtask

  initial begin
    bus.in0 = SS_DEF; bus.in1 = SS_DEF; bus.in2 = SS_DEF; bus.in3 = SS_DEF;
    bus.blank = 4'b0000;
    bus.load  = 1'b0;
    model_reset();

    // Reset asserted between edges acts at once.
    #2 rst = 1'b1;
    #1;
    chk("rst_segs",  32'(bus.segs),    32'(8'hFF));
    chk("rst_ctl",   32'(bus.ssd_ctl), 32'(4'hF));
    chk("rst_pend",  32'(bus.pending), 32'(1'b0));
    chk("rst_frame", 32'(bus.frame),   32'(1'b0));
    repeat (5) @(posedge clk);
    #1;
    chk("rsth_segs",  32'(bus.segs),    32'(8'hFF));
    chk("rsth_ctl",   32'(bus.ssd_ctl), 32'(4'hF));
    chk("rsth_pend",  32'(bus.pending), 32'(1'b0));
    chk("rsth_frame", 32'(bus.frame),   32'(1'b0));
    rst = 1'b0;
    model_reset();

    // Scan pattern: load on the wrap edge, then one full frame.
    run_to(31);
    load_vals(SS_0, SS_1, SS_2, SS_3, 4'b0000);
    chk("wrapload_pend", 32'(bus.pending), 32'(1'b0));
    chk("wrapload_ctl",  32'(bus.ssd_ctl), 32'(4'h7));
    chk("wrapload_segs", 32'(bus.segs),    32'(SS_3));
    fr = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      chk("scan_ctl", 32'(bus.ssd_ctl), 32'(SCAN_CTL[i]));
      if (i == 5)  chk("scan_d0", 32'(bus.segs), 32'(SS_0));
      if (i == 21) chk("scan_d2", 32'(bus.segs), 32'(SS_2));
      fr = fr + int'(bus.frame);
    end
    chk("frame_count", 32'(fr), 32'd1);

    // Double buffering: mid-slot-1 update waits for the frame boundary.
    run_to(12);
    load_vals(SS_0, SS_9, SS_2, SS_3, 4'b0000);
    chk("db_pend_set", 32'(bus.pending), 32'(1'b1));
    step();
    chk("db_old_digit", 32'(bus.segs), 32'(SS_1));
    run_to(31);
    step();
    chk("db_pend_clr", 32'(bus.pending), 32'(1'b0));
    run_to(10);
    step();
    chk("db_new_ctl",  32'(bus.ssd_ctl), 32'(4'hD));
    chk("db_new_segs", 32'(bus.segs),    32'(SS_9));

    // Last load in a frame wins.
    run_to(20);
    load_vals(SS_5, SS_9, SS_2, SS_3, 4'b0000);
    run_to(28);
    load_vals(SS_7, SS_9, SS_2, SS_3, 4'b0000);
    run_to(31);
    step();
    run_to(2);
    step();
    chk("llw_ctl",  32'(bus.ssd_ctl), 32'(4'hE));
    chk("llw_segs", 32'(bus.segs),    32'(SS_7));

    // Blank digit 3.
    load_vals(SS_7, SS_9, SS_2, SS_3, 4'b1000);
    run_to(0);
    for (int i = 0; i < 32; i++) begin
      step();
      if (i >= 24) begin
        chk("blank_ctl",  32'(bus.ssd_ctl), 32'(4'hF));
        chk("blank_segs", 32'(bus.segs),    32'(8'hFF));
      end
      if (i == 10) chk("blank_d1", 32'(bus.segs), 32'(SS_9));
    end

    // Reset during a digit-2 enable with an update pending.
    load_vals(SS_1, SS_1, SS_1, SS_1, 4'b0000);
    run_to(20);
    step();
    chk("pre_rst_ctl",  32'(bus.ssd_ctl), 32'(4'hB));
    chk("pre_rst_pend", 32'(bus.pending), 32'(1'b1));
    #2 rst = 1'b1;
    #1;
    chk("mrst_ctl",  32'(bus.ssd_ctl), 32'(4'hF));
    chk("mrst_segs", 32'(bus.segs),    32'(8'hFF));
    chk("mrst_pend", 32'(bus.pending), 32'(1'b0));
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run_to(2);
    step();
    chk("post_rst_ctl",  32'(bus.ssd_ctl), 32'(4'hE));
    chk("post_rst_segs", 32'(bus.segs),    32'(8'hFF));
    for (int i = 0; i < 40; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
